// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the
// system ID slave. Only the signals a two-word read needs are carried.
interface nios_system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/nios_system_sysid_checker.sv
// System ID checker: reads ID (word 0) and build timestamp (word 1) from the
// sysid slave and flags whether both match the values this image expects.
// A check runs once after reset (AUTO_START) and on every accepted start.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1425347263,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          AUTO_START         = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    nios_system_sysid_checker_if.master        avm,
    output logic                               busy,
    output logic                               done,
    output logic                               id_match,
    output logic                               ts_match,
    output logic                               timeout,
    output logic [31:0]                        id_value,
    output logic [31:0]                        ts_value
);

    // The abort decision is made in the last allowed stall cycle, so the
    // counter is compared against one less than the limit; done then lands
    // in the following cycle and a read never stalls longer than the limit.
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] stall_cnt;
    logic        boot_pending;   // high only in the first cycle after reset
    logic        id_eq;          // ID compare, held until the timestamp lands
    logic        in_read;
    logic        stall_expired;
    logic        launch;

    assign in_read       = (state == RD_ID) || (state == RD_TS);
    assign stall_expired = avm.avm_waitrequest && (stall_cnt == STALL_LAST);
    assign launch        = (state == IDLE) &&
                           (start || ((AUTO_START != 0) && boot_pending));

    // Next-state and Moore outputs; bus strobes come straight from the state
    // so address/read stay stable for the whole stall.
    always_comb begin
        state_nxt       = state;
        avm.avm_read    = 1'b0;
        avm.avm_address = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (launch) state_nxt = RD_ID;
            end
            RD_ID: begin
                avm.avm_read = 1'b1;
                if (!avm.avm_waitrequest) state_nxt = RD_TS;
                else if (stall_expired)   state_nxt = FINISH;
            end
            RD_TS: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = 1'b1;
                if (!avm.avm_waitrequest || stall_expired) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus the one-shot post-reset launch marker.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            boot_pending <= 1'b1;
        end else begin
            state        <= state_nxt;
            boot_pending <= 1'b0;
        end
    end

    // Stall counter: counts while a read stays in place, zero otherwise, so
    // it is already clear on entry to every read state.
    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt <= '0;
        else if (in_read && avm.avm_waitrequest && (state_nxt == state))
            stall_cnt <= stall_cnt + 16'd1;
        else
            stall_cnt <= '0;
    end

    // Captured words and result flags; flags settle on the edge into FINISH
    // so they are valid alongside done.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_value <= '0;
            ts_value <= '0;
            id_eq    <= 1'b0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        id_match <= 1'b0;
                        ts_match <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                RD_ID: begin
                    if (!avm.avm_waitrequest) begin
                        id_value <= avm.avm_readdata;
                        id_eq    <= (avm.avm_readdata == EXPECTED_ID);
                    end else if (stall_expired) begin
                        id_match <= 1'b0;
                        ts_match <= 1'b0;
                        timeout  <= 1'b1;
                    end
                end
                RD_TS: begin
                    if (!avm.avm_waitrequest) begin
                        ts_value <= avm.avm_readdata;
                        id_match <= id_eq;
                        ts_match <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
                        timeout  <= 1'b0;
                    end else if (stall_expired) begin
                        id_match <= 1'b0;
                        ts_match <= 1'b0;
                        timeout  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench for the sysid checker: a scripted slave whose stall and
// returned words are set step by step from one initial block.
module tb_nios_system_sysid_checker;

    localparam logic [31:0] TS = 32'd1425347263;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        wr;
    logic [31:0] id_word;
    logic [31:0] ts_word;
    logic        busy, done, id_match, ts_match, timeout;
    logic [31:0] id_value, ts_value;

    int total  = 0;
    int passed = 0;
    int n;
    logic stable;

    nios_system_sysid_checker_if bus ();

    assign bus.avm_waitrequest = wr;
    assign bus.avm_readdata    = bus.avm_address ? ts_word : id_word;

    nios_system_sysid_checker #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (TS),
        .TIMEOUT_CYCLES     (8),
        .AUTO_START         (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .avm      (bus),
        .busy     (busy),
        .done     (done),
        .id_match (id_match),
        .ts_match (ts_match),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Pulse start, then count cycles until done (bounded).
    task automatic run_check(output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wr = 1'b0;
        id_word = 32'd0; ts_word = TS;
        tick(); tick();

        // reset state
        chk("rst_read",  bus.avm_read, 0);
        chk("rst_addr",  bus.avm_address, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_flags", {id_match, ts_match, timeout}, 0);
        chk("rst_idv",   id_value, 0);
        chk("rst_tsv",   ts_value, 0);

        // auto start on first post-reset cycle
        reset = 1'b0;
        tick();
        chk("auto_rd_id", {busy, bus.avm_read, bus.avm_address}, 3'b110);
        tick();
        chk("auto_rd_ts", {bus.avm_read, bus.avm_address}, 2'b11);
        tick();
        chk("auto_done",  {done, id_match, ts_match, timeout}, 4'b1110);
        tick();
        chk("auto_idle",  {busy, done, id_match}, 3'b001);

        // zero-wait check: done exactly 3 cycles after start
        run_check(n);
        chk("zw_latency", n, 3);
        chk("zw_flags",   {id_match, ts_match, timeout}, 3'b110);
        chk("zw_tsv",     ts_value, TS);
        tick();

        // wrong ID
        id_word = 32'h0000_0001;
        run_check(n);
        chk("badid_latency", n, 3);
        chk("badid_flags",   {id_match, ts_match, timeout}, 3'b010);
        chk("badid_idv",     id_value, 32'h0000_0001);
        tick();

        // 4 stall cycles on each read: done at N+11
        id_word = 32'd0;
        wr = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!(bus.avm_read && !bus.avm_address && !done)) stable = 1'b0;
            tick();
        end
        wr = 1'b0;
        if (!(bus.avm_read && !bus.avm_address)) stable = 1'b0;
        chk("stall_id_hold", stable, 1);
        tick();
        wr = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!(bus.avm_read && bus.avm_address && !done)) stable = 1'b0;
            tick();
        end
        wr = 1'b0;
        if (!(bus.avm_read && bus.avm_address && !done)) stable = 1'b0;
        chk("stall_ts_hold", stable, 1);
        tick();
        chk("stall_done", {done, id_match, ts_match, timeout}, 4'b1110);
        tick();

        // timeout in RD_TS after 8 stalled cycles
        id_word = 32'h0000_1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!(bus.avm_read && bus.avm_address && !done)) stable = 1'b0;
            tick();
        end
        chk("to_hold",  stable, 1);
        chk("to_done",  {done, bus.avm_read, timeout, id_match, ts_match}, 5'b10100);
        chk("to_idv",   id_value, 32'h0000_1234);
        chk("to_tsv",   ts_value, TS);
        wr = 1'b0;
        tick();
        chk("to_after", {busy, done, timeout}, 3'b001);

        // start while busy: exactly one done
        id_word = 32'd0;
        start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) n++;
            tick();
        end
        chk("busy_start_dones", n, 1);
        chk("busy_start_flags", {id_match, ts_match, timeout}, 3'b110);

        // start in the done cycle is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("done_cycle", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_busy", busy, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) n++;
            tick();
        end
        chk("done_start_idle", n, 0);

        // reset during a stalled RD_ID, then auto check
        wr = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_bus",   {bus.avm_read, bus.avm_address, busy, done}, 0);
        chk("midrst_flags", {id_match, ts_match, timeout}, 0);
        chk("midrst_tsv",   ts_value, 0);
        wr = 1'b0; reset = 1'b0;
        tick();
        chk("midrst_auto", {busy, bus.avm_read, bus.avm_address}, 3'b110);
        tick(); tick();
        chk("midrst_done", {done, id_match, ts_match, timeout}, 4'b1110);
        chk("midrst_tsv2", ts_value, TS);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
